circular_fifo: RTL
==================

// Module: circular_fifo
// PURPOSE
//  Programmable-depth FIFO built on wrap-around read/write pointers. Each pointer
//  advances by one per accepted beat and returns to 0 after the runtime limit.
//  Sits between a valid/ready producer and consumer in control/datapath chains.
//  Occupancy and full/empty flags drive upstream throttling logic.
// PARAMETERS
//  WIDTH       8  data word width in bits
//  ADDR_WIDTH  4  pointer width; physical storage = 2**ADDR_WIDTH words
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             asynchronous, active-high reset
//  max_index  in   ADDR_WIDTH    unsigned runtime limit; usable depth = max_index+1
//  s_valid    in   1             producer has a word
//  s_ready    out  1             FIFO accepts a word this cycle
//  s_data     in   WIDTH         producer word
//  m_valid    out  1             FIFO holds a word for the consumer
//  m_ready    in   1             consumer takes the word this cycle
//  m_data     out  WIDTH         head word (first-word fall-through)
//  count      out  ADDR_WIDTH+1  current occupancy, 0..max_index+1
//  full       out  1             count == limit+1
//  empty      out  1             count == 0
// BEHAVIOUR
//  Clock and reset: one clock, clk. rst is asynchronous and active-high.
//  Reset (async assert): wr_ptr=0, rd_ptr=0, count=0, cfg_max=0 -> empty=1,
//   full=0, m_valid=0, s_ready=1. Storage array is not reset.
//  Reset mid-operation discards all contents immediately. First write after
//   deassert lands at index 0.
//  Effective limit: lim = empty ? max_index : cfg_max.
//  cfg_max loads max_index on every edge where count==0.
//  max_index changes while non-empty take effect only after the FIFO drains.
//  Handshakes:
//   - wr = s_valid & s_ready; rd = m_valid & m_ready.
//   - s_ready = !full; m_valid = !empty. Both are combinational from registered state.
//   - m_data = mem[rd_ptr], combinational. Valid whenever m_valid=1.
//  Latency: a word written at edge N is visible on m_data/m_valid after edge N.
//   There is no same-cycle bypass when empty.
//  Write while empty: word goes to mem[0]. Next wr_ptr = (lim==0)?0:1; next rd_ptr=0.
//  Empty with no write: wr_ptr and rd_ptr are both forced to 0. This keeps
//   pointers in range after a limit change.
//  Non-empty pointer update: on wr, mem[wr_ptr]<=s_data and wr_ptr <= (wr_ptr==lim)?0:wr_ptr+1.
//   On rd, rd_ptr wraps identically.
//  count arithmetic:
//   - wr&!rd -> +1; rd&!wr -> -1; both or neither -> unchanged.
//   - Width ADDR_WIDTH+1 so that count == 2**ADDR_WIDTH is representable.
//  Full and simultaneous rd: s_ready=0, so no write is accepted that cycle.
//   The read completes; s_ready rises on the next cycle.
//  Empty: m_valid=0; m_ready is ignored.
//  lim==0 (depth 1): alternates full/empty. Peak throughput is 1 word per 2 cycles.
//  Unsynthesizable-free; no X on outputs after reset except m_data while empty.
// STRUCTURE
//  Shared package or header: none needed. Widths derive from parameters only.
//  Sub-module: circular_ptr. It is a wrap counter (clk, rst async, inc, clr, lim ->
//   ptr) and is instantiated twice. clr forces 0. Wrap rule is ptr==lim -> 0.
//  Top level holds the storage array, count/cfg_max registers and the handshake logic.
// TESTING
//  1. Reset, then max_index=3, write 4 words A0..A3 -> full=1 and s_ready=0 after the
//     4th; count=4. A 5th s_valid is held off. Drain -> A0..A3 in order, then empty=1.
//  2. max_index=2, stream 10 words with m_ready=1 continuously -> all words come out
//     in order, 1-cycle write-to-valid latency, pointers wrap 2->0 with no loss.
//  3. Full (max_index=1, count=2), assert s_valid and m_ready together -> only the
//     read happens, count=1. Next cycle the write is accepted and count stays 1.
//  4. Fill 3 words with max_index=7, change max_index to 1, drain -> count 3->0 with
//     the old wrap. Next writes wrap at index 1 and full asserts at count=2.
//  5. Assert rst asynchronously mid-stream (between edges) -> empty=1, count=0 and
//     m_valid=0 immediately. The next written word reads back first.
//  6. max_index=0 -> write, read, write, read. full toggles 1/0 and count toggles 1/0.
//     Data is correct on every beat.

Source files
------------

// File: rtl/circular_fifo_pkg.sv
// Shared defaults for the circular FIFO slice.
// Contents:
//   DEF_WIDTH       default data word width
//   DEF_ADDR_WIDTH  default pointer width (physical storage = 2**DEF_ADDR_WIDTH words)
package circular_fifo_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/circular_fifo_ptr.sv
// circular_ptr: wrap-around pointer register for the circular FIFO.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset, pointer -> 0
//   inc  in   advance the pointer by one beat
//   clr  in   restart the pointer from 0
//   lim  in   highest legal index; the pointer steps from lim back to 0
//   ptr  out  current pointer value
module circular_ptr
    import circular_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] lim,
    output logic [ADDR_WIDTH-1:0] ptr
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [ADDR_WIDTH-1:0] base;

    // clr and inc together mean "restart at 0, then take one step": this is
    // what a write into an empty FIFO needs (word lands at 0, pointer moves on).
    always_comb begin
        base  = clr ? '0 : ptr_q;
        ptr_d = base;
        if (inc) begin
            ptr_d = (base == lim) ? '0 : base + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/circular_fifo.sv
// circular_fifo: programmable-depth first-word-fall-through FIFO using
// wrap-around read/write pointers. Usable depth is max_index+1 words.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset (contents discarded)
//   max_index  in   runtime wrap limit, sampled into cfg_max while empty
//   s_valid    in   producer has a word
//   s_ready    out  FIFO can accept a word (not full)
//   s_data     in   producer word
//   m_valid    out  FIFO holds a word (not empty)
//   m_ready    in   consumer takes the head word
//   m_data     out  head word, combinational from storage
//   count      out  occupancy, 0..max_index+1
//   full       out  count == limit+1
//   empty      out  count == 0
module circular_fifo
    import circular_fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] max_index,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic [ADDR_WIDTH-1:0] cfg_max_q;
    logic [ADDR_WIDTH-1:0] cfg_max_d;

    logic [ADDR_WIDTH-1:0] lim;
    logic [ADDR_WIDTH:0]   depth;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr;
    logic                  rd;

    assign empty   = (count_q == '0);
    // While empty the live max_index applies; once data is held the limit is
    // frozen in cfg_max so pointers never see a limit they were not built with.
    assign lim     = empty ? max_index : cfg_max_q;
    assign depth   = {1'b0, lim} + (ADDR_WIDTH + 1)'(1);
    assign full    = (count_q == depth);
    assign s_ready = !full;
    assign m_valid = !empty;
    assign wr      = s_valid && s_ready;
    assign rd      = m_valid && m_ready;
    // A pointer left mid-array by the last drain is ignored: an empty FIFO
    // always restarts at index 0.
    assign wr_addr = empty ? '0 : wr_ptr;
    assign m_data  = mem_q[rd_ptr];
    assign count   = count_q;

    circular_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr),
        .clr (empty),
        .lim (lim),
        .ptr (wr_ptr)
    );

    circular_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd),
        .clr (empty),
        .lim (lim),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_d   = count_q;
        cfg_max_d = cfg_max_q;
        if (wr && !rd) begin
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end else if (rd && !wr) begin
            count_d = count_q - (ADDR_WIDTH + 1)'(1);
        end
        if (empty) begin
            cfg_max_d = max_index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            cfg_max_q <= '0;
        end else begin
            count_q   <= count_d;
            cfg_max_q <= cfg_max_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_addr] <= s_data;
        end
    end

endmodule
